// File: rtl/xrv1_fetch_buffer_pkg.sv
// Shared constants for the xrv1 fetch buffer and its static branch scanner.
// Holds the RV32I/RVC opcode encodings the scanner recognises and the default
// queue depth of the fetch buffer.
package xrv1_fetch_buffer_pkg;

   localparam int unsigned IFQ_SIZE_DEFAULT = 3;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [1:0] RVC_Q1 = 2'b01;

   localparam logic [2:0] C_F3_JAL  = 3'b001;
   localparam logic [2:0] C_F3_J    = 3'b101;
   localparam logic [2:0] C_F3_BEQZ = 3'b110;
   localparam logic [2:0] C_F3_BNEZ = 3'b111;

   // A halfword starts a 16-bit instruction unless its low two bits are 11.
   function automatic logic is_rvc(input logic [1:0] op);
      return op != 2'b11;
   endfunction

endpackage

// File: rtl/xrv1_branch_spec.sv
// Static control-transfer predictor for one instruction.
//   insn   : instruction bits (RVC in [15:0] when rv16=1)
//   pc     : address of that instruction
//   rv16   : 1 = decode as RVC, 0 = decode as 32-bit
//   vld    : a predictable transfer was found (JAL/C.J/C.JAL always,
//            conditional branches only when the offset is negative)
//   target : pc + sign-extended offset, modulo 2^32
module xrv1_branch_spec
   import xrv1_fetch_buffer_pkg::*;
(
   input  logic [31:0] insn,
   input  logic [31:0] pc,
   input  logic        rv16,
   output logic        vld,
   output logic [31:0] target
);

   logic [31:0] imm_j;
   logic [31:0] imm_b;
   logic [31:0] imm_cj;
   logic [31:0] imm_cb;
   logic [31:0] imm;

   assign imm_j  = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
   assign imm_b  = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
   assign imm_cj = {{21{insn[12]}}, insn[8], insn[10:9], insn[6], insn[7],
                    insn[2], insn[11], insn[5:3], 1'b0};
   assign imm_cb = {{24{insn[12]}}, insn[6:5], insn[2], insn[11:10],
                    insn[4:3], 1'b0};

   // The sign bit of the offset doubles as the backward-taken hint.
   always_comb begin
      vld = 1'b0;
      imm = '0;
      if (rv16) begin
         if (insn[1:0] == RVC_Q1) begin
            case (insn[15:13])
               C_F3_J, C_F3_JAL: begin
                  vld = 1'b1;
                  imm = imm_cj;
               end
               C_F3_BEQZ, C_F3_BNEZ: begin
                  vld = insn[12];
                  imm = imm_cb;
               end
               default: ;
            endcase
         end
      end else begin
         case (insn[6:0])
            OPC_JAL: begin
               vld = 1'b1;
               imm = imm_j;
            end
            OPC_BRANCH: begin
               vld = insn[31];
               imm = imm_b;
            end
            default: ;
         endcase
      end
   end

   assign target = pc + imm;

endmodule

// File: rtl/xrv1_fetch_buffer.sv
// Instruction fetch buffer: queues IMEM words with their fetch PCs and
// presents one aligned 16/32-bit instruction per cycle to decode. Also scans
// the incoming IMEM word for statically predictable jumps/branches.
//   clk_i, rst_ni        : clock, async active-low reset
//   flush_i              : drop all queued words (redirect)
//   enqueue_i            : push fetch_data_i / fetch_pc_i (dropped when full)
//   dequeue_i            : decode consumed the presented instruction
//   fetch_data_vld_o     : presented instruction is complete
//   fetch_data_o/pc_o    : aligned instruction and its PC
//   empty_o/full_o/almost_full_o : queue occupancy flags
//   spec_pc_vld_o/spec_pc_o      : predicted target for the incoming word
module xrv1_fetch_buffer
   import xrv1_fetch_buffer_pkg::*;
#(
   parameter int unsigned ifq_size_p = IFQ_SIZE_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic        enqueue_i,
   input  logic        dequeue_i,
   input  logic [31:0] fetch_data_i,
   input  logic [31:0] fetch_pc_i,
   output logic        fetch_data_vld_o,
   output logic [31:0] fetch_data_o,
   output logic [31:0] fetch_pc_o,
   output logic        empty_o,
   output logic        full_o,
   output logic        almost_full_o,
   output logic        spec_pc_vld_o,
   output logic [31:0] spec_pc_o
);

   localparam int PTR_W = (ifq_size_p > 1) ? $clog2(ifq_size_p) : 1;
   localparam int CNT_W = $clog2(ifq_size_p + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(ifq_size_p - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ifq_size_p);
   localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(ifq_size_p - 1);

   logic [31:0]      word_q [ifq_size_p];
   logic [31:0]      pc_q   [ifq_size_p];
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [CNT_W-1:0] count_q;
   logic             half_q;

   logic [PTR_W-1:0] head_nxt;
   logic [31:0]      w0;
   logic [31:0]      w1;
   logic [31:0]      head_pc;
   logic             h;
   logic             is32;
   logic             push;
   logic             pop;
   logic             take;
   logic             half_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign head_nxt = ptr_inc(head_q);
   assign w0       = word_q[head_q];
   assign w1       = word_q[head_nxt];
   assign head_pc  = pc_q[head_q];

   // An unaligned entry PC and a consumed lower half both start at the upper half.
   assign h    = head_pc[1] | half_q;
   assign is32 = h ? !is_rvc(w0[17:16]) : !is_rvc(w0[1:0]);

   always_comb begin
      fetch_data_o     = '0;
      fetch_data_vld_o = 1'b0;
      if (!h) begin
         fetch_data_o     = is32 ? w0 : {16'h0000, w0[15:0]};
         fetch_data_vld_o = (count_q != '0);
      end else begin
         fetch_data_o     = is32 ? {w1[15:0], w0[31:16]} : {16'h0000, w0[31:16]};
         fetch_data_vld_o = is32 ? (count_q >= CNT_W'(2)) : (count_q != '0);
      end
   end

   assign fetch_pc_o    = {head_pc[31:2], h, 1'b0};
   assign empty_o       = (count_q == '0);
   assign full_o        = (count_q == CNT_FULL);
   assign almost_full_o = (count_q == CNT_AF);

   // Only a 16-bit instruction in the lower half leaves the head word in place;
   // a straddling 32-bit instruction leaves the next word half consumed.
   assign take   = dequeue_i & fetch_data_vld_o;
   assign pop    = take & (h | is32);
   assign push   = enqueue_i & ~full_o;
   assign half_d = h ? is32 : ~is32;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         half_q  <= 1'b0;
      end else if (flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         half_q  <= 1'b0;
      end else begin
         if (push) tail_q <= ptr_inc(tail_q);
         if (pop)  head_q <= head_nxt;
         if (take) half_q <= half_d;
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push && !flush_i) begin
         word_q[tail_q] <= fetch_data_i;
         pc_q[tail_q]   <= fetch_pc_i;
      end
   end

   logic        spec_w_vld;
   logic [31:0] spec_w_pc;
   logic        spec_c_vld;
   logic [31:0] spec_c_pc;

   xrv1_branch_spec u_spec_word (
      .insn   (fetch_data_i),
      .pc     ({fetch_pc_i[31:2], 2'b00}),
      .rv16   (1'b0),
      .vld    (spec_w_vld),
      .target (spec_w_pc)
   );

   xrv1_branch_spec u_spec_half (
      .insn   ({16'h0000, fetch_data_i[31:16]}),
      .pc     ({fetch_pc_i[31:1], 1'b0}),
      .rv16   (1'b1),
      .vld    (spec_c_vld),
      .target (spec_c_pc)
   );

   assign spec_pc_vld_o = fetch_pc_i[1] ? (spec_c_vld & is_rvc(fetch_data_i[17:16]))
                                        : spec_w_vld;
   assign spec_pc_o     = fetch_pc_i[1] ? spec_c_pc : spec_w_pc;

   logic unused_bits;
   assign unused_bits = ^{fetch_pc_i[0], head_pc[0], w1[31:16]};

endmodule

// File: tb/tb_xrv1_fetch_buffer.sv
module tb_xrv1_fetch_buffer;

   localparam int SIZE = 3;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush_i = 1'b0;
   logic        enqueue_i = 1'b0;
   logic        dequeue_i = 1'b0;
   logic [31:0] fetch_data_i = '0;
   logic [31:0] fetch_pc_i = '0;
   logic        fetch_data_vld_o;
   logic [31:0] fetch_data_o;
   logic [31:0] fetch_pc_o;
   logic        empty_o;
   logic        full_o;
   logic        almost_full_o;
   logic        spec_pc_vld_o;
   logic [31:0] spec_pc_o;

   xrv1_fetch_buffer #(.ifq_size_p(SIZE)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .enqueue_i(enqueue_i), .dequeue_i(dequeue_i),
      .fetch_data_i(fetch_data_i), .fetch_pc_i(fetch_pc_i),
      .fetch_data_vld_o(fetch_data_vld_o), .fetch_data_o(fetch_data_o),
      .fetch_pc_o(fetch_pc_o), .empty_o(empty_o), .full_o(full_o),
      .almost_full_o(almost_full_o), .spec_pc_vld_o(spec_pc_vld_o),
      .spec_pc_o(spec_pc_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: the buffer is a stream of halfwords; "last" marks the
   // halfword whose consumption frees a word slot.
   typedef struct {
      logic [15:0] hw;
      logic [31:0] addr;
      bit          last;
   } hw_t;

   typedef struct {
      bit          vld;
      logic [31:0] pc;
   } spec_t;

   hw_t   hw_q[$];
   spec_t spec_q[$];
   int    words = 0;
   int    n_chk = 0;
   int    n_fail = 0;
   bit    mon_on = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_vld();
      if (hw_q.size() == 0) return 1'b0;
      if (hw_q[0].hw[1:0] != 2'b11) return 1'b1;
      return hw_q.size() >= 2;
   endfunction

   function automatic logic [31:0] m_data();
      if (hw_q[0].hw[1:0] != 2'b11) return {16'h0000, hw_q[0].hw};
      return {hw_q[1].hw, hw_q[0].hw};
   endfunction

   task automatic model_apply(input bit enq, input logic [31:0] d, input logic [31:0] p,
                              input bit deq, input bit fl);
      hw_t e;
      bit  was_full;
      int  n;
      if (fl) begin
         hw_q.delete();
         words = 0;
      end else begin
         was_full = (words == SIZE);
         if (deq && m_vld()) begin
            n = (hw_q[0].hw[1:0] == 2'b11) ? 2 : 1;
            for (int k = 0; k < n; k++) begin
               if (hw_q[0].last) words--;
               void'(hw_q.pop_front());
            end
         end
         if (enq && !was_full) begin
            if (!p[1]) begin
               e.hw = d[15:0]; e.addr = {p[31:2], 2'b00}; e.last = 1'b0;
               hw_q.push_back(e);
            end
            e.hw = d[31:16]; e.addr = {p[31:2], 2'b10}; e.last = 1'b1;
            hw_q.push_back(e);
            words++;
         end
      end
   endtask

   task automatic step(input bit enq, input logic [31:0] d, input logic [31:0] p,
                       input bit deq, input bit fl, input bit sv, input logic [31:0] sp);
      spec_t s;
      enqueue_i = enq; fetch_data_i = d; fetch_pc_i = p; dequeue_i = deq; flush_i = fl;
      s.vld = sv; s.pc = sp;
      spec_q.push_back(s);
      @(posedge clk_i);
      model_apply(enq, d, p, deq, fl);
      #1;
   endtask

   task automatic idle(input bit deq);
      step(1'b0, 32'h0, 32'h0, deq, 1'b0, 1'b0, 32'h0);
   endtask

   always @(negedge clk_i) begin
      spec_t s;
      if (mon_on) begin
         chk("valid", {31'b0, fetch_data_vld_o}, {31'b0, m_vld()});
         chk("empty", {31'b0, empty_o}, {31'b0, words == 0});
         chk("full", {31'b0, full_o}, {31'b0, words == SIZE});
         chk("almost_full", {31'b0, almost_full_o}, {31'b0, words == SIZE - 1});
         if (m_vld() && fetch_data_vld_o) begin
            chk("data", fetch_data_o, m_data());
            chk("pc", fetch_pc_o, hw_q[0].addr);
         end
         if (spec_q.size() > 0) begin
            s = spec_q.pop_front();
            chk("spec_vld", {31'b0, spec_pc_vld_o}, {31'b0, s.vld});
            if (s.vld) chk("spec_pc", spec_pc_o, s.pc);
         end
      end
   end

   function automatic logic [31:0] enc_jal(input logic [31:0] o, input logic [4:0] rd);
      return {o[20], o[10:1], o[11], o[19:12], rd, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_b(input logic [31:0] o, input logic [2:0] f3,
                                         input logic [4:0] rs1, input logic [4:0] rs2);
      return {o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], 7'b1100011};
   endfunction

   function automatic logic [15:0] enc_cj(input logic [31:0] o, input logic [2:0] f3);
      return {f3, o[11], o[4], o[9:8], o[10], o[6], o[7], o[3:1], o[5], 2'b01};
   endfunction

   function automatic logic [15:0] enc_cb(input logic [31:0] o, input logic [2:0] f3,
                                          input logic [2:0] rs);
      return {f3, o[8], o[4:3], rs, o[7:6], o[2:1], o[5], 2'b01};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r, r2, r3, p, d, off, sp;
      logic [15:0] c;
      bit          sv, enq;
      int          kind;

      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      chk("reset_valid", {31'b0, fetch_data_vld_o}, 32'd0);
      chk("reset_empty", {31'b0, empty_o}, 32'd1);
      chk("reset_full", {31'b0, full_o}, 32'd0);
      chk("reset_almost_full", {31'b0, almost_full_o}, 32'd0);
      mon_on = 1'b1;

      // single 32-bit word
      step(1, 32'h00000013, 32'h100, 0, 0, 0, 0);
      chk("t1_valid", {31'b0, fetch_data_vld_o}, 32'd1);
      chk("t1_data", fetch_data_o, 32'h00000013);
      chk("t1_pc", fetch_pc_o, 32'h100);
      chk("t1_empty", {31'b0, empty_o}, 32'd0);
      idle(1);

      // two RVC halves in one word
      step(1, 32'h45014501, 32'h200, 0, 0, 0, 0);
      chk("t2_data0", fetch_data_o, 32'h00004501);
      chk("t2_pc0", fetch_pc_o, 32'h200);
      idle(1);
      chk("t2_data1", fetch_data_o, 32'h00004501);
      chk("t2_pc1", fetch_pc_o, 32'h202);
      idle(1);
      chk("t2_empty", {31'b0, empty_o}, 32'd1);

      // 32-bit instruction straddling a word boundary
      step(1, 32'h00134501, 32'h300, 0, 0, 0, 0);
      step(1, 32'h11110000, 32'h304, 0, 0, 0, 0);
      chk("t3_data0", fetch_data_o, 32'h00004501);
      idle(1);
      chk("t3_data1", fetch_data_o, 32'h00000013);
      chk("t3_pc1", fetch_pc_o, 32'h302);
      idle(1);
      chk("t3_data2", fetch_data_o, 32'h00001111);
      chk("t3_pc2", fetch_pc_o, 32'h306);
      idle(1);

      // unaligned entry point, 32-bit instruction needs the next word
      step(1, 32'h0013ABCD, 32'h402, 0, 0, 0, 0);
      chk("t4_wait", {31'b0, fetch_data_vld_o}, 32'd0);
      step(1, 32'h00000000, 32'h404, 0, 0, 0, 0);
      chk("t4_valid", {31'b0, fetch_data_vld_o}, 32'd1);
      chk("t4_data", fetch_data_o, 32'h00000013);
      chk("t4_pc", fetch_pc_o, 32'h402);
      step(0, 0, 0, 0, 1, 0, 0);

      // fill, overflow, flush
      step(1, 32'h00000013, 32'h500, 0, 0, 0, 0);
      step(1, 32'h00000013, 32'h504, 0, 0, 0, 0);
      chk("t5_af", {31'b0, almost_full_o}, 32'd1);
      step(1, 32'h00000013, 32'h508, 0, 0, 0, 0);
      chk("t5_full", {31'b0, full_o}, 32'd1);
      step(1, 32'h00000033, 32'h50C, 1, 0, 0, 0);
      chk("t5_drop_deq", {31'b0, almost_full_o}, 32'd1);
      chk("t5_head_pc", fetch_pc_o, 32'h504);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("t5_flush_empty", {31'b0, empty_o}, 32'd1);

      // branch scan vectors
      step(0, 32'hFE000EE3, 32'h1000, 0, 0, 1, 32'h00000FFC);
      chk("t6_beq_back", spec_pc_o, 32'h00000FFC);
      step(0, 32'h0080006F, 32'h1000, 0, 0, 1, 32'h00001008);
      chk("t6_jal", spec_pc_o, 32'h00001008);
      step(0, 32'h00000463, 32'h1000, 0, 0, 0, 0);
      chk("t6_beq_fwd", {31'b0, spec_pc_vld_o}, 32'd0);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         r = $urandom; r2 = $urandom; r3 = $urandom;
         kind = $urandom_range(0, 5);
         p = {r3[31:2], 2'b00};
         sv = 1'b0; sp = 32'h0; d = {r2[31:7], 7'b0010011};
         case (kind)
            0: begin
               off = {{11{r[20]}}, r[20:1], 1'b0};
               d = enc_jal(off, r[25:21]);
               sv = 1'b1; sp = p + off;
            end
            1: begin
               off = {{19{r[12]}}, r[12:1], 1'b0};
               d = enc_b(off, r[15:13], r[20:16], r[25:21]);
               sv = off[31]; sp = p + off;
            end
            2: begin
               p = {r3[31:2], 2'b10};
               off = {{20{r[11]}}, r[11:1], 1'b0};
               c = enc_cj(off, r[12] ? 3'b101 : 3'b001);
               d = {c, r2[15:0]};
               sv = 1'b1; sp = p + off;
            end
            3: begin
               p = {r3[31:2], 2'b10};
               off = {{23{r[8]}}, r[8:1], 1'b0};
               c = enc_cb(off, r[9] ? 3'b110 : 3'b111, r[14:12]);
               d = {c, r2[15:0]};
               sv = off[31]; sp = p + off;
            end
            5: begin
               p = {r3[31:2], 2'b10};
               c = {r2[31:18], (r[0] ? 2'b00 : (r[1] ? 2'b10 : 2'b11))};
               d = {c, r2[15:0]};
            end
            default: ;
         endcase
         enq = ($urandom_range(0, 2) != 0) && (!p[1] || words == 0);
         step(enq, d, p, $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0, sv, sp);
      end

      idle(0);
      @(negedge clk_i); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/xrv1_fetch_buffer.md
# xrv1_fetch_buffer

Instruction fetch buffer for the xrv1 core front end: holds raw 32-bit IMEM words with their fetch PCs, aligns 16/32-bit instructions across halfword boundaries, and hands one instruction per cycle to decode. It also scans the incoming IMEM word for statically predictable control transfers so the fetch unit can redirect early. Sits between the IMEM response path and the RVC expander/decoder.

## Interface
- `ifq_size_p`, 3: queue depth in 32-bit words (≥2).
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `flush_i` in 1: synchronous flush on branch/jump redirect.
- `enqueue_i` in 1: push `fetch_data_i`/`fetch_pc_i`.
- `dequeue_i` in 1: decode consumes the presented instruction.
- `fetch_data_i` in 32: IMEM response word.
- `fetch_pc_i` in 32: fetch PC of that word; bit 1 marks an unaligned entry point.
- `fetch_data_vld_o` out 1: presented instruction complete.
- `fetch_data_o` out 32: aligned instruction, 16-bit in [15:0] with upper bits 0.
- `fetch_pc_o` out 32: PC of the presented instruction.
- `empty_o`, `full_o`, `almost_full_o` out 1: count==0, ==`ifq_size_p`, ==`ifq_size_p`-1.
- `spec_pc_vld_o` out 1, `spec_pc_o` out 32: predicted target for `fetch_data_i`.

## Operation
- Storage: circular buffer of {word, pc}, head/tail pointers wrapping at `ifq_size_p`, count, halfword flag `half_q`.
- Effective offset `h = head_pc[1] | half_q`; `fetch_pc_o = {head_pc[31:2], h, 1'b0}`.
- Alignment (head word W0, next word W1):
  - h=0, W0[1:0]!=11: 16-bit, data={16'b0,W0[15:0]}, valid if count≥1.
  - h=0, W0[1:0]==11: 32-bit, data=W0, valid if count≥1.
  - h=1, W0[17:16]!=11: 16-bit, data={16'b0,W0[31:16]}, valid if count≥1.
  - h=1, W0[17:16]==11: 32-bit, data={W1[15:0],W0[31:16]}, valid only if count≥2.
- Dequeue (ignored when `fetch_data_vld_o`=0):
  - h=0/16-bit: no pop, `half_q`←1.
  - h=0/32-bit, h=1/16-bit: pop head, `half_q`←0.
  - h=1/32-bit: pop head, `half_q`←1.
- Enqueue while full is dropped, even with simultaneous dequeue. Simultaneous enqueue+pop: count unchanged.
- `flush_i`: count, pointers, `half_q` ← 0; same-cycle enqueue/dequeue ignored.
- Branch scan (combinational on `fetch_data_i`, `fetch_pc_i`):
  - `fetch_pc_i[1]`=0: scan word as 32-bit at pc {pc[31:2],00}. JAL (opcode 1101111) always predicted; branch (1100011) predicted only if insn[31]=1 (backward).
  - `fetch_pc_i[1]`=1: scan upper half as RVC at pc {pc[31:1],0}, only if [17:16]!=11. C.J/C.JAL (op 01, funct3 101/001) always; C.BEQZ/C.BNEZ (110/111) if imm sign bit insn[12]=1.
  - Immediates sign-extended per RV32IC J/B/CJ/CB formats; target = pc + imm modulo 2^32. No match: `spec_pc_vld_o`=0, `spec_pc_o` don't-care.

## Timing
- Reset: empty, `half_q`=0; `fetch_data_vld_o`=0, `empty_o`=1, `full_o`=0, `almost_full_o`=(`ifq_size_p`==1 ? 1 : 0).
- Enqueued word is presentable the following cycle (no internal bypass; fetch unit bypasses).
- All outputs combinational from registered state, except branch-scan outputs, which are combinational from inputs.
- Pointer/flag updates on posedge `clk_i`; flush has priority over everything except reset.

## Structure
- Shared package: opcode constants (JAL, BRANCH, RVC quadrant/funct3), `ifq_size_p` default.
- Sub-modules: `xrv1_branch_spec` (pure combinational, insn/pc/rv16 → vld/target, instantiated twice); alignment mux inline.

## Test plan
- Reset then push {0x00000013, pc 0x100}: next cycle valid, data 0x00000013, pc 0x100, `empty_o`=0.
- Push word 0x45014501 at 0x200: dequeue → pc 0x200 data 0x4501, then pc 0x202 data 0x4501, then empty.
- Push 0x00134501 at 0x300, 0x11110000 at 0x304: 16-bit at 0x300, then 32-bit at 0x302 data 0x00000013, then 16-bit at 0x306 data 0x1111.
- Jump to unaligned: push 0x0013xxxx at 0x402 alone → invalid until second word arrives.
- Fill 3 entries → `full_o`=1; extra enqueue dropped; `flush_i` → `empty_o`=1 next cycle.
- `fetch_data_i`=0xFE000EE3 (beq backward −4), pc 0x1000 → spec 0x00000FFC; 0x0080006F (jal +8) → 0x1008; forward beq → `spec_pc_vld_o`=0.
